irq_pending_arbiter: RTL and testbench

Sequential front end for the 8-input lower-bit priority encoder path. Latches request pulses into a sticky pending register and applies an enable mask. Selects the lowest-numbered pending, enabled source (bit 0 has highest priority) and presents its index to the downstream consumer with a valid/ack handshake. Clears the serviced bit on ack and counts serviced events.

---
 rtl/irq_pending_arbiter.sv | 84 ++++++++
 tb/tb_irq_pending_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_arbiter.sv
// Sticky interrupt pending register with lowest-index-first grant
// and a valid/ack handshake toward the consumer.
module irq_pending_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ack,
    output logic [N-1:0]     pending,
    output logic [CNT_W-1:0] serviced_cnt
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]       state;
    logic [N-1:0]     elig;
    logic [N-1:0]     clr;
    logic [IDX_W-1:0] sel;
    logic             any;
    logic             done;

    assign elig = pending & mask;
    assign any  = |elig;
    assign done = (state == GRANT) && out_ack;

    // Scan from the top so the lowest set index is the last writer.
    always_comb begin
        sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel = IDX_W'(i);
            end
        end
    end

    always_comb begin
        clr = '0;
        if (done) begin
            clr[out_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending      <= '0;
            out_valid    <= 1'b0;
            out_idx      <= '0;
            serviced_cnt <= '0;
            state        <= IDLE;
        end else begin
            // A request landing on the bit being cleared is kept.
            pending <= (pending & ~clr) | req;
            unique case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (any) begin
                        out_idx   <= sel;
                        out_valid <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (out_ack) begin
                        serviced_cnt <= serviced_cnt + 1'b1;
                        out_valid    <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Randomized + directed bench for irq_pending_arbiter with a
// queue-based scoreboard fed by a set-based reference model.
module tb_irq_pending_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic [7:0] mask;
    logic [2:0] out_idx;
    logic       out_valid;
    logic       out_ack;
    logic [7:0] pending;
    logic [7:0] serviced_cnt;

    irq_pending_arbiter #(.N(8), .IDX_W(3), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .mask         (mask),
        .out_idx      (out_idx),
        .out_valid    (out_valid),
        .out_ack      (out_ack),
        .pending      (pending),
        .serviced_cnt (serviced_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int idx;
        int pend;
        int cnt;
    } exp_t;

    exp_t expq[$];
    int   grantq[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference: set of pending sources, a "being served" flag,
    // the source currently offered and a modulo-256 tally.
    bit   mp[8];
    bit   mbusy = 0;
    int   midx  = 0;
    int   mcnt  = 0;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input logic [7:0] r,
                        input logic [7:0] m, input bit a);
        int   lo;
        bit   served;
        int   sidx;
        int   pv;
        exp_t e;
        @(negedge clk);
        reset   = rst;
        req     = r;
        mask    = m;
        out_ack = a;
        if (rst) begin
            foreach (mp[i]) mp[i] = 0;
            mbusy = 0;
            midx  = 0;
            mcnt  = 0;
        end else begin
            lo = -1;
            for (int i = 0; i < 8; i++)
                if (lo < 0 && mp[i] && m[i]) lo = i;
            served = mbusy && a;
            sidx   = midx;
            for (int i = 0; i < 8; i++)
                mp[i] = (mp[i] && !(served && i == sidx)) || r[i];
            if (!mbusy) begin
                if (lo >= 0) begin
                    mbusy = 1;
                    midx  = lo;
                    grantq.push_back(lo);
                end
            end else if (a) begin
                mbusy = 0;
                mcnt  = (mcnt + 1) % 256;
            end
        end
        pv = 0;
        for (int i = 0; i < 8; i++)
            if (mp[i]) pv += (1 << i);
        e.v    = mbusy;
        e.idx  = midx;
        e.pend = pv;
        e.cnt  = mcnt;
        expq.push_back(e);
    endtask

    bit prev_v = 0;

    always @(posedge clk) begin
        exp_t e;
        int   g;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("out_valid", int'(out_valid), int'(e.v));
            chk("out_idx", int'(out_idx), e.idx);
            chk("pending", int'(pending), e.pend);
            chk("serviced_cnt", int'(serviced_cnt), e.cnt);
        end
        if (out_valid && !prev_v) begin
            if (grantq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL grant: got idx %0d expected no grant",
                         out_idx);
            end else begin
                g = grantq.pop_front();
                chk("grant_idx", int'(out_idx), g);
            end
        end
        prev_v = out_valid;
    end

    initial begin
        int  n;
        bit  a;
        logic [7:0] r;
        logic [7:0] m;
        reset   = 1'b1;
        req     = '0;
        mask    = '0;
        out_ack = 1'b0;

        step(1, 8'h00, 8'h00, 0);
        step(1, 8'h00, 8'h00, 0);
        repeat (5) step(0, 8'h00, 8'hFF, 0);

        step(0, 8'hA4, 8'hFF, 0);
        repeat (12) step(0, 8'h00, 8'hFF, mbusy);

        step(0, 8'h03, 8'hFE, 0);
        repeat (6) step(0, 8'h00, 8'hFE, mbusy);
        repeat (4) step(0, 8'h00, 8'hFF, mbusy);

        step(0, 8'h08, 8'hFF, 0);
        step(0, 8'h00, 8'hFF, 0);
        step(0, 8'h01, 8'hFF, 0);
        repeat (3) step(0, 8'h00, 8'hFF, 0);
        step(0, 8'h00, 8'hFF, 1);
        repeat (6) step(0, 8'h00, 8'hFF, mbusy);

        step(0, 8'h10, 8'hFF, 0);
        step(0, 8'h00, 8'hFF, 0);
        step(0, 8'h10, 8'hFF, 1);
        repeat (6) step(0, 8'h00, 8'hFF, mbusy);

        // Mask drop mid-grant must not abort the grant.
        step(0, 8'h40, 8'hFF, 0);
        step(0, 8'h00, 8'hFF, 0);
        step(0, 8'h00, 8'h00, 0);
        step(0, 8'h00, 8'h00, 1);
        repeat (3) step(0, 8'h00, 8'h00, 1);

        step(1, 8'h00, 8'hFF, 0);
        n = 0;
        while (n < 256) begin
            a = mbusy;
            step(0, 8'h01, 8'hFF, a);
            if (a) n++;
        end
        step(0, 8'h00, 8'hFF, 0);
        while (!mbusy) step(0, 8'h00, 8'hFF, 0);
        step(0, 8'h00, 8'hFF, 0);
        step(1, 8'h00, 8'hFF, 0);
        step(0, 8'h00, 8'hFF, 0);
        step(0, 8'h00, 8'hFF, 0);

        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            m = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            a = ($urandom_range(0, 2) != 0);
            step($urandom_range(0, 299) == 0, r, m, a);
        end

        repeat (3) step(0, 8'h00, 8'hFF, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        if (expq.size() != 0 || grantq.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d cycles and %0d grants unchecked",
                     expq.size(), grantq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
